// File: rtl/t07_pkg.sv
// Shared types and frame geometry for the t07 SPI frame receive path.
package t07_pkg;

  localparam int FRAME_BITS = 64;
  localparam int LANE_BITS  = 8;
  localparam int WORD_BITS  = 32;

  typedef enum logic [1:0] {
    RX_WAIT_CS = 2'd0,
    RX_IDLE    = 2'd1,
    RX_SHIFT   = 2'd2
  } state_rx_t;

  typedef struct packed {
    logic [WORD_BITS-1:0] addr;
    logic [WORD_BITS-1:0] data;
  } rx_word_t;

  // Frame lanes, high to low: A3 D3 A2 D2 A1 D1 A0 D0.
  function automatic rx_word_t deinterleave(input logic [FRAME_BITS-1:0] s);
    rx_word_t w;
    w = '0;
    for (int l = 0; l < 4; l++) begin
      w.addr[l*LANE_BITS +: LANE_BITS] = s[(2*l+1)*LANE_BITS +: LANE_BITS];
      w.data[l*LANE_BITS +: LANE_BITS] = s[(2*l)*LANE_BITS +: LANE_BITS];
    end
    return w;
  endfunction

endpackage

// File: rtl/t07_spi_rx_fifo.sv
// First-word-fall-through buffer for completed frames.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module t07_spi_rx_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // A pop on an empty buffer is ignored, so a push into an empty buffer is
  // always visible for at least one cycle. When full, a same-cycle pop frees
  // the slot the push needs.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointer advance on accepted push/pop.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage; cleared at reset so the head reads zero until the first push.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/t07_spi_frame_rx.sv
// SPI mode-0 peripheral receiver: synchronises the master's pins, shifts
// 64-bit frames MSB first, splits them into address/data and queues them.
//
//  state      | meaning
//  RX_WAIT_CS | waiting for cs_n high; sclk ignored (reset release or frame done)
//  RX_IDLE    | cs_n high, bit count held at zero, waiting for cs_n low
//  RX_SHIFT   | frame in progress, one bit shifted per sclk rise
module t07_spi_frame_rx
  import t07_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 sclk_i,
  input  logic                 cs_n_i,
  input  logic                 mosi_i,
  input  logic                 ready_i,
  output logic                 valid_o,
  output logic [WORD_BITS-1:0] addr_o,
  output logic [WORD_BITS-1:0] data_o,
  output logic                 busy_o,
  output logic                 frame_err_o,
  output logic                 overrun_o
);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_s;
  logic                   cs_s;
  logic                   mosi_s;
  logic                   sclk_d1;
  logic                   rise;

  logic [1:0]             prime_cnt;
  logic                   primed;

  state_rx_t              state;
  logic [6:0]             count;
  logic [FRAME_BITS-2:0]  shreg;
  logic                   ovl;
  logic                   post_frame;

  logic [FRAME_BITS-1:0]  frame;
  logic                   last_rise;
  rx_word_t               push_word;
  rx_word_t               head_word;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic                   pop;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_d1;
  assign primed = (prime_cnt == 2'd0);

  // Pin synchronisers plus the sclk edge-detect delay tap.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d1   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
      sclk_d1   <= sclk_s;
    end
  end

  // The cs_n chain resets to "deselected"; until real pin values have
  // propagated through it, WAIT_CS must not trust that value or a frame
  // already in flight at reset release would be picked up part-way.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      prime_cnt <= 2'(SYNC_STAGES);
    end else if (!primed) begin
      prime_cnt <= prime_cnt - 2'd1;
    end
  end

  // The 64th bit goes straight from the sync chain into the FIFO in the
  // cycle its rise is detected, so the entry is visible one clock later.
  assign frame     = {shreg, mosi_s};
  assign last_rise = (state == RX_SHIFT) && !cs_s && rise &&
                     (count == 7'(FRAME_BITS - 1));
  assign push_word = deinterleave(frame);

  // Frame FSM, shift register, bit counter and the frame-error pulse.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= RX_WAIT_CS;
      count       <= '0;
      shreg       <= '0;
      ovl         <= 1'b0;
      post_frame  <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      frame_err_o <= 1'b0;
      case (state)
        RX_WAIT_CS: begin
          if (primed && cs_s) begin
            state       <= RX_IDLE;
            frame_err_o <= ovl;
            ovl         <= 1'b0;
            post_frame  <= 1'b0;
          end else if (rise && !cs_s && post_frame) begin
            // Extra clocks after a complete frame: flag it, report on release.
            ovl <= 1'b1;
          end
        end
        RX_IDLE: begin
          count <= '0;
          if (!cs_s) state <= RX_SHIFT;
        end
        RX_SHIFT: begin
          if (cs_s) begin
            frame_err_o <= (count != 7'd0);
            count       <= '0;
            state       <= RX_IDLE;
          end else if (rise) begin
            shreg <= frame[FRAME_BITS-2:0];
            count <= count + 7'd1;
            if (count == 7'(FRAME_BITS - 1)) begin
              state      <= RX_WAIT_CS;
              post_frame <= 1'b1;
            end
          end
        end
        default: state <= RX_WAIT_CS;
      endcase
    end
  end

  // A completed frame that finds the FIFO full with no pop is dropped.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      overrun_o <= 1'b0;
    end else begin
      overrun_o <= last_rise & fifo_full & ~pop;
    end
  end

  t07_spi_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FRAME_BITS)
  ) u_fifo (
    .clk       (clk),
    .nrst      (nrst),
    .push      (last_rise),
    .push_data (push_word),
    .pop       (pop),
    .head      (head_word),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign valid_o = ~fifo_empty;
  assign pop     = valid_o & ready_i;
  assign addr_o  = head_word.addr;
  assign data_o  = head_word.data;
  assign busy_o  = (state == RX_SHIFT) && (count != 7'd0);

endmodule
